// File: rtl/rv32_ctrl_fsm.sv
// rv32_ctrl_fsm -- multi-cycle RV32 control sequencer.
// FETCH -> DECODE -> EXEC -> [MEM] -> WB, with a sticky HALT on ECALL.
// Optional build macro ILLEGAL_OP_TRAP_EN: unknown opcodes halt the core and
// raise a sticky trap output; without it they retire as a NOP.
// All outputs are forced low while reset_n is low, so requests drop
// asynchronously and the first fetch request appears as soon as reset lifts.
module rv32_ctrl_fsm #(
   parameter int PC_SEL_W = 2,
   parameter int WB_SEL_W = 2
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [6:0]          opcode,
   input  logic                br_taken,
   output logic                imem_req,
   input  logic                imem_ready,
   output logic                dmem_req,
   output logic                dmem_we,
   input  logic                dmem_ready,
   output logic                ir_we,
   output logic                pc_we,
   output logic                rf_we,
   output logic [PC_SEL_W-1:0] pc_sel,
   output logic [WB_SEL_W-1:0] wb_sel,
   output logic                alu_src_imm,
   output logic                halted,
   output logic [2:0]          state,
   output logic [31:0]         instret
`ifdef ILLEGAL_OP_TRAP_EN
   ,
   output logic                trap
`endif
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_ECALL  = 7'b1110011;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] instret_reg, instret_next;

   logic is_load, is_store, is_ecall, is_branch, is_op, is_jal, is_jalr, is_lui;
   logic writes_rf;

   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);
   assign is_ecall  = (opcode == OPC_ECALL);
   assign is_branch = (opcode == OPC_BRANCH);
   assign is_op     = (opcode == OPC_OP);
   assign is_jal    = (opcode == OPC_JAL);
   assign is_jalr   = (opcode == OPC_JALR);
   assign is_lui    = (opcode == OPC_LUI);
   // Unknown opcodes fall outside this set, so they never write the register file.
   assign writes_rf = is_lui | (opcode == OPC_AUIPC) | is_jal | is_jalr |
                      is_load | (opcode == OPC_OPIMM) | is_op;

`ifdef ILLEGAL_OP_TRAP_EN
   logic op_legal;
   logic trap_reg, trap_next;
   assign op_legal = writes_rf | is_branch | is_store | is_ecall;
   assign trap     = trap_reg;
`endif

   // State, retired-instruction counter and (optional) trap flag registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= ST_FETCH;
         instret_reg <= 32'd0;
`ifdef ILLEGAL_OP_TRAP_EN
         trap_reg    <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         instret_reg <= instret_next;
`ifdef ILLEGAL_OP_TRAP_EN
         trap_reg    <= trap_next;
`endif
      end
   end

   // Next-state logic and output decode; unused codes 6/7 recover to FETCH.
   always_comb begin
      state_next   = ST_FETCH;
      instret_next = instret_reg;
`ifdef ILLEGAL_OP_TRAP_EN
      trap_next    = trap_reg;
`endif
      imem_req     = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      rf_we        = 1'b0;
      pc_sel       = '0;
      wb_sel       = '0;
      alu_src_imm  = 1'b0;
      halted       = 1'b0;
      case (state_reg)
         ST_FETCH: begin
            imem_req = 1'b1;
            ir_we    = imem_ready;
            state_next = imem_ready ? ST_DECODE : ST_FETCH;
         end
         ST_DECODE: begin
            state_next = ST_EXEC;
         end
         ST_EXEC: begin
            alu_src_imm = !(is_op || is_branch);
            if (is_load || is_store) begin
               state_next = ST_MEM;
            end else if (is_ecall) begin
               state_next = ST_HALT;
            end else begin
               state_next = ST_WB;
`ifdef ILLEGAL_OP_TRAP_EN
               if (!op_legal) begin
                  state_next = ST_HALT;
                  trap_next  = 1'b1;
               end
`endif
            end
         end
         ST_MEM: begin
            alu_src_imm = 1'b1;
            dmem_req    = 1'b1;
            dmem_we     = is_store;
            state_next  = dmem_ready ? ST_WB : ST_MEM;
         end
         ST_WB: begin
            alu_src_imm  = !(is_op || is_branch);
            pc_we        = 1'b1;
            rf_we        = writes_rf;
            instret_next = instret_reg + 32'd1;
            if (is_load) begin
               wb_sel = WB_SEL_W'(1);
            end else if (is_jal || is_jalr) begin
               wb_sel = WB_SEL_W'(2);
            end else if (is_lui) begin
               wb_sel = WB_SEL_W'(3);
            end
            if (is_jal || (is_branch && br_taken)) begin
               pc_sel = PC_SEL_W'(1);
            end else if (is_jalr) begin
               pc_sel = PC_SEL_W'(2);
            end
            state_next = ST_FETCH;
         end
         ST_HALT: begin
            halted     = 1'b1;
            state_next = ST_HALT;
         end
         default: begin
            state_next = ST_FETCH;
         end
      endcase
      // Hold every output low while reset is asserted.
      if (!reset_n) begin
         imem_req    = 1'b0;
         dmem_req    = 1'b0;
         dmem_we     = 1'b0;
         ir_we       = 1'b0;
         pc_we       = 1'b0;
         rf_we       = 1'b0;
         pc_sel      = '0;
         wb_sel      = '0;
         alu_src_imm = 1'b0;
         halted      = 1'b0;
      end
   end

   assign state   = state_reg;
   assign instret = instret_reg;

endmodule

// File: tb/tb_rv32_ctrl_fsm.sv
// tb_rv32_ctrl_fsm -- directed bench for rv32_ctrl_fsm.
// Covers reset, steady fetch/execute cadence, memory waits, branch/jump
// decode, illegal opcodes (both builds of ILLEGAL_OP_TRAP_EN), async reset
// mid-store and the sticky HALT after ECALL.
module tb_rv32_ctrl_fsm;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_ECALL  = 7'b1110011;
   localparam logic [6:0] OPC_BAD    = 7'b1111111;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [6:0]  opcode;
   logic        br_taken, imem_ready, dmem_ready;
   logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we;
   logic [1:0]  pc_sel, wb_sel;
   logic        alu_src_imm, halted;
   logic [2:0]  state;
   logic [31:0] instret;
`ifdef ILLEGAL_OP_TRAP_EN
   logic        trap;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_instret = 32'd0;

   rv32_ctrl_fsm #(.PC_SEL_W(2), .WB_SEL_W(2)) dut (
      .clock(clock), .reset_n(reset_n), .opcode(opcode), .br_taken(br_taken),
      .imem_req(imem_req), .imem_ready(imem_ready),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
      .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
      .pc_sel(pc_sel), .wb_sel(wb_sel), .alu_src_imm(alu_src_imm),
      .halted(halted), .state(state), .instret(instret)
`ifdef ILLEGAL_OP_TRAP_EN
      , .trap(trap)
`endif
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle 1 ns past the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Runs one non-memory instruction starting from FETCH with imem_ready=1.
   task automatic run_simple(input logic [6:0] op, input logic br,
                             input logic [1:0] e_pc, input logic [1:0] e_wb,
                             input logic e_rf, input logic e_alu);
      opcode = op; br_taken = br;
      #1;
      chk("fetch_state", state, 0);
      chk("fetch_ir_we", ir_we, 1);
      step();
      chk("decode_state", state, 1);
      step();
      chk("exec_state", state, 2);
      chk("exec_alu_imm", alu_src_imm, e_alu);
      step();
      chk("wb_state", state, 4);
      chk("wb_pc_we", pc_we, 1);
      chk("wb_pc_sel", pc_sel, e_pc);
      chk("wb_wb_sel", wb_sel, e_wb);
      chk("wb_rf_we", rf_we, e_rf);
      chk("wb_alu_imm", alu_src_imm, e_alu);
      exp_instret = exp_instret + 1;
      step();
      chk("retire_state", state, 0);
      chk("retire_instret", instret, exp_instret);
      $display("op %b br %0d retired, instret %0d", op, br, instret);
   endtask

   task automatic reset_pulse();
      reset_n = 1'b0;
      #1;
      chk("rst_state", state, 0);
      chk("rst_instret", instret, 0);
      chk("rst_imem_req", imem_req, 0);
      chk("rst_halted", halted, 0);
`ifdef ILLEGAL_OP_TRAP_EN
      chk("rst_trap", trap, 0);
`endif
      reset_n = 1'b1;
      exp_instret = 32'd0;
      #1;
      chk("rel_imem_req", imem_req, 1);
   endtask

   initial begin
      int seq [4];
      int cnt;
      seq = '{0, 1, 2, 4};
      reset_n = 1'b0; opcode = OPC_OP; br_taken = 1'b0;
      imem_ready = 1'b1; dmem_ready = 1'b0;

      // Reset state with imem_ready already high.
      repeat (3) step();
      chk("reset_state", state, 0);
      chk("reset_instret", instret, 0);
      chk("reset_imem_req", imem_req, 0);
      chk("reset_ir_we", ir_we, 0);
      chk("reset_pc_we", pc_we, 0);
      chk("reset_pc_sel", pc_sel, 0);
      chk("reset_wb_sel", wb_sel, 0);
      chk("reset_halted", halted, 0);
      reset_n = 1'b1;
      #1;
      chk("first_imem_req", imem_req, 1);
      chk("first_ir_we", ir_we, 1);

      // OP stream with zero-wait fetch: F,D,E,WB repeating.
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("cad_state", state, seq[k % 4]);
         chk("cad_pc_we", pc_we, (seq[k % 4] == 4) ? 1 : 0);
         if (seq[k % 4] == 4) chk("cad_rf_we", rf_we, 1);
         if (seq[k % 4] == 2) chk("cad_alu_imm", alu_src_imm, 0);
         if (k == 4) chk("cad_instret1", instret, 1);
      end
      exp_instret = 32'd2;
      chk("cad_instret2", instret, exp_instret);
      $display("OP cadence done, instret %0d", instret);

      // LOAD with fetch wait and dmem_ready delayed 3 cycles.
      opcode = OPC_LOAD; imem_ready = 1'b0; dmem_ready = 1'b0;
      #1;
      chk("fwait_imem_req", imem_req, 1);
      chk("fwait_ir_we", ir_we, 0);
      step();
      chk("fwait_state", state, 0);
      imem_ready = 1'b1;
      #1;
      chk("fwait_ir_we_done", ir_we, 1);
      step();
      step();
      chk("ld_exec_alu", alu_src_imm, 1);
      step();
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         chk("ld_mem_state", state, 3);
         chk("ld_dmem_we", dmem_we, 0);
         if (dmem_req) cnt++;
         if (i == 2) dmem_ready = 1'b1;
         step();
      end
      chk("ld_req_cycles", cnt, 3);
      chk("ld_wb_state", state, 4);
      chk("ld_wb_sel", wb_sel, 1);
      chk("ld_rf_we", rf_we, 1);
      chk("ld_wb_dmem_req", dmem_req, 0);
      dmem_ready = 1'b0;
      exp_instret = exp_instret + 1;
      step();
      chk("ld_instret", instret, exp_instret);
      $display("LOAD retired, instret %0d", instret);

      // STORE with immediate ready.
      opcode = OPC_STORE; dmem_ready = 1'b1;
      step(); step(); step();
      chk("st_mem_state", state, 3);
      chk("st_dmem_req", dmem_req, 1);
      chk("st_dmem_we", dmem_we, 1);
      step();
      chk("st_wb_rf_we", rf_we, 0);
      dmem_ready = 1'b0;
      exp_instret = exp_instret + 1;
      step();
      chk("st_instret", instret, exp_instret);
      $display("STORE retired, instret %0d", instret);

      // Branch/jump/upper-immediate decode table.
      run_simple(OPC_BRANCH, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0);
      run_simple(OPC_BRANCH, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
      run_simple(OPC_JAL,    1'b0, 2'd1, 2'd2, 1'b1, 1'b1);
      run_simple(OPC_JALR,   1'b1, 2'd2, 2'd2, 1'b1, 1'b1);
      run_simple(OPC_LUI,    1'b0, 2'd0, 2'd3, 1'b1, 1'b1);
      run_simple(OPC_AUIPC,  1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
      run_simple(OPC_OPIMM,  1'b1, 2'd0, 2'd0, 1'b1, 1'b1);
      br_taken = 1'b0;

      // Illegal opcode.
`ifdef ILLEGAL_OP_TRAP_EN
      opcode = OPC_BAD;
      step(); step();
      chk("ill_exec_state", state, 2);
      step();
      chk("ill_state", state, 5);
      chk("ill_halted", halted, 1);
      chk("ill_trap", trap, 1);
      chk("ill_pc_we", pc_we, 0);
      step();
      chk("ill_trap_sticky", trap, 1);
      chk("ill_instret", instret, exp_instret);
      $display("illegal opcode trapped, instret %0d", instret);
      reset_pulse();
`else
      run_simple(OPC_BAD, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
`endif

      // Async reset during a stalled STORE.
      opcode = OPC_STORE; dmem_ready = 1'b0;
      step(); step(); step();
      chk("rs_mem_state", state, 3);
      chk("rs_dmem_req", dmem_req, 1);
      chk("rs_dmem_we", dmem_we, 1);
      step();
      chk("rs_mem_hold", dmem_req, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rs_dmem_req_drop", dmem_req, 0);
      chk("rs_dmem_we_drop", dmem_we, 0);
      chk("rs_state", state, 0);
      chk("rs_instret", instret, 0);
      reset_n = 1'b1;
      exp_instret = 32'd0;
      #1;
      chk("rs_restart_req", imem_req, 1);
      chk("rs_restart_state", state, 0);
      $display("reset during STORE, restarted in FETCH");

      // ECALL halts and stays halted.
      opcode = OPC_ECALL;
      step(); step();
      step();
      chk("ec_state", state, 5);
      chk("ec_halted", halted, 1);
      cnt = 0;
      for (int i = 0; i < 22; i++) begin
         step();
         if (imem_req || ir_we || pc_we || dmem_req) cnt++;
      end
      chk("ec_quiet_cycles", cnt, 0);
      chk("ec_state_sticky", state, 5);
      chk("ec_halted_sticky", halted, 1);
      chk("ec_instret", instret, exp_instret);
`ifdef ILLEGAL_OP_TRAP_EN
      chk("ec_no_trap", trap, 0);
`endif
      $display("ECALL halted, instret %0d", instret);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
